tlul_lsu_host: RTL and testbench
================================

Name: tlul_lsu_host

Overview:
- TL-UL host (initiator) adapter.
- Converts a simple req/gnt memory-port request from the core load-store unit into TL-UL A-channel transactions, and returns D-channel responses as rvalid/rdata/err.
- Counterpart of the SRAM-backed TL-UL devices (data memory, instruction memory): it drives tl_h2d_t and consumes tl_d2h_t.
- Supports up to MaxOutstanding in-flight transactions; responses are required in order.

Parameters:
- MaxOutstanding, 2, max accepted-but-unanswered transactions (power of 2, 1..8); also the source-ID space.
- SrcW, 3, width of source counter used in a_source; must satisfy 2**SrcW >= MaxOutstanding; upper a_source bits are zero.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; synchronous, active-low
- req_i  input  1  LSU request valid
- gnt_o  output  1  request accepted this cycle (req_i && gnt_o)
- we_i  input  1  1 = write, 0 = read
- addr_i  input  32  byte address
- wdata_i  input  32  write data
- be_i  input  4  byte enables (writes only)
- rvalid_o  output  1  response valid, one-cycle pulse
- rdata_o  output  32  read data (0 for write responses)
- err_o  output  1  response error, qualified by rvalid_o
- busy_o  output  1  outstanding count != 0 or A channel valid
- unexp_o  output  1  sticky: D response received with nothing outstanding
- tl_h_o  output  tl_h2d_t  TL-UL A channel + d_ready
- tl_h_i  input  tl_d2h_t  TL-UL D channel + a_ready

Behaviour:
- Reset values (rst_ni low at clock edge): a_valid=0, all tl_h_o fields 0 except d_ready=1; rvalid_o=0, rdata_o=0, err_o=0, unexp_o=0; outstanding count=0; source counter=0; response FIFO empty.
- Grant: gnt_o = (cnt < MaxOutstanding) && (!a_valid_q || a_ready). Combinational from a_ready.
  - cnt counts accepted transactions whose D response has not yet arrived, including one still held on the A channel.
- A channel is registered. On accept at cycle N, at N+1: a_valid=1 and the fields below are loaded.
  - a_opcode: Get (4) for reads; PutFullData (0) for writes with be_i=4'hF; PutPartialData (1) for other writes, including be_i=0.
  - a_param=0; a_size=2.
  - a_address = {addr_i[31:2], 2'b00}.
  - a_mask = 4'hF for reads, be_i for writes.
  - a_data = wdata_i for writes, 0 for reads.
  - a_source = source counter; a_user = default.
- A-channel fields stay stable while a_valid=1 && !a_ready.
- a_valid drops the cycle after a_ready, unless a new request was accepted in that same cycle (back-to-back issue).
- Source counter increments modulo MaxOutstanding on every accept.
- Response FIFO, depth MaxOutstanding, pushes {source, we} on accept.
- d_ready is constantly 1.
- On d_valid with cnt>0: pop the FIFO head. At the next cycle:
  - rvalid_o=1.
  - rdata_o = d_data if the head was a read, else 0.
  - err_o = d_error | (d_source != head.source) | (d_opcode != AccessAckData for a read, or != AccessAck for a write).
- On d_valid with cnt==0: no pop, no rvalid_o; unexp_o set, held until reset.
- Accept and response in the same cycle: cnt unchanged; FIFO pushes and pops.
- cnt==MaxOutstanding: gnt_o=0 until a response arrives. gnt_o can rise in the same cycle as d_valid only if MaxOutstanding>cnt after the pop. The pop is combinational into the grant: gnt_o = (cnt - d_pop < MaxOutstanding) && ....
- Latency against a zero-wait device that responds the cycle after the A handshake: accept N, a_valid N+1, d_valid N+2, rvalid_o N+3.
- Reset mid-operation clears all state. Late D responses to pre-reset requests then hit cnt==0 and set unexp_o.
- Source counter wrap: with MaxOutstanding=2 the sources issued are 0,1,0,1,...

Test Plan:
- Single read: req addr 0x0000_0104, we=0 → next cycle a_valid, Get, a_address 0x104, mask F, size 2, source 0. Device returns AccessAckData d_data 0xDEADBEEF → one cycle later rvalid_o=1, rdata_o 0xDEADBEEF, err_o=0.
- Partial write: we=1, be=4'b0011, wdata 0x1234_5678, addr 0x202 → PutPartialData, address 0x200, mask 3. AccessAck → rvalid_o=1, rdata_o=0, err_o=0. Repeat with be=F → PutFullData.
- Backpressure and full: hold a_ready=0 for 5 cycles with two reads issued back-to-back → A fields stable; gnt_o=0 once cnt=2. Release → sources 0 then 1 issued. Responses → two rvalid_o pulses in order; gnt_o returns 1 in the cycle of the first d_valid.
- Error paths: d_error=1 → err_o=1. d_source=1 while head is 0 → err_o=1. AccessAck returned for a read → err_o=1.
- Unexpected response: d_valid with no outstanding transaction → no rvalid_o, unexp_o=1 held. Reset → unexp_o=0.
- Reset mid-transaction: reset asserted while a_valid=1 and cnt=1 → next cycle a_valid=0, cnt=0, gnt_o=1. The stale D response then sets unexp_o.

Source files
------------

// File: rtl/tlul_lsu_host.sv
// TL-UL host adapter: turns the LSU req/gnt port into TL-UL A-channel beats
// and returns in-order D-channel responses as rvalid/rdata/err.

package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = 4;
  localparam int unsigned TL_UW  = 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic [TL_UW-1:0]    a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic [TL_UW-1:0]    d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

endpackage

module tlul_lsu_host
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcW           = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             be_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic                   unexp_o,
  output tlul_pkg::tl_h2d_t      tl_h_o,
  input  tlul_pkg::tl_d2h_t      tl_h_i
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [SrcW-1:0] src;
    logic            we;
  } rsp_entry_t;

  tl_h2d_t          a_q;
  logic [CntW-1:0]  cnt_q;
  logic [SrcW-1:0]  src_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  rsp_entry_t       fifo_q [MaxOutstanding];
  logic             rvalid_q, err_q, unexp_q;
  logic [31:0]      rdata_q;

  logic             accept, d_pop, d_stray, rsp_err;
  logic [CntW-1:0]  cnt_after_pop;
  rsp_entry_t       head;
  tl_a_op_e         a_opcode_d;
  tl_d_op_e         d_opcode_exp;
  logic             unused_inputs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == MaxOutstanding - 1) ? '0 : p + PtrW'(1);
  endfunction

  function automatic logic [SrcW-1:0] src_inc(input logic [SrcW-1:0] s);
    return (32'(s) == MaxOutstanding - 1) ? '0 : s + SrcW'(1);
  endfunction

  // FIFO occupancy always equals cnt_q, so cnt_q doubles as its fill level.
  assign d_pop         = tl_h_i.d_valid && (cnt_q != '0);
  assign d_stray       = tl_h_i.d_valid && (cnt_q == '0);
  assign cnt_after_pop = cnt_q - CntW'(d_pop);
  assign gnt_o         = (32'(cnt_after_pop) < MaxOutstanding) &&
                         (!a_q.a_valid || tl_h_i.a_ready);
  assign accept        = req_i && gnt_o;
  assign head          = fifo_q[rd_ptr_q];
  assign busy_o        = (cnt_q != '0) || a_q.a_valid;

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign unexp_o       = unexp_q;

  assign unused_inputs = ^{addr_i[1:0], tl_h_i.d_param, tl_h_i.d_size,
                           tl_h_i.d_sink, tl_h_i.d_user};

  // Request decode: opcode selection and expected response opcode for the head.
  always_comb begin
    a_opcode_d = Get;
    if (we_i) begin
      a_opcode_d = (be_i == 4'hF) ? PutFullData : PutPartialData;
    end
    d_opcode_exp = head.we ? AccessAck : AccessAckData;
    rsp_err = tl_h_i.d_error ||
              (tl_h_i.d_source != TL_AIW'(head.src)) ||
              (tl_h_i.d_opcode != d_opcode_exp);
  end

  // Output struct: registered A channel with d_ready tied high.
  always_comb begin
    tl_h_o         = a_q;
    tl_h_o.d_ready = 1'b1;
  end

  // A-channel register: load on accept, hold under backpressure, drop after handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q <= '0;
    end else if (accept) begin
      a_q.a_valid   <= 1'b1;
      a_q.a_opcode  <= a_opcode_d;
      a_q.a_param   <= '0;
      a_q.a_size    <= 2'd2;
      a_q.a_source  <= TL_AIW'(src_q);
      a_q.a_address <= {addr_i[31:2], 2'b00};
      a_q.a_mask    <= we_i ? be_i : 4'hF;
      a_q.a_data    <= we_i ? wdata_i : '0;
      a_q.a_user    <= '0;
      a_q.d_ready   <= 1'b0;
    end else if (tl_h_i.a_ready) begin
      a_q.a_valid <= 1'b0;
    end
  end

  // Outstanding count, source counter and response FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      src_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(accept) - CntW'(d_pop);
      if (accept) begin
        src_q    <= src_inc(src_q);
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (d_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Response FIFO storage: {source, we} of each accepted request.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= '{src: src_q, we: we_i};
    end
  end

  // Response register and sticky unexpected-response flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      unexp_q  <= 1'b0;
    end else begin
      rvalid_q <= d_pop;
      rdata_q  <= (d_pop && !head.we) ? tl_h_i.d_data : '0;
      err_q    <= d_pop && rsp_err;
      unexp_q  <= unexp_q || d_stray;
    end
  end

endmodule

// File: tb/tb_tlul_lsu_host.sv
// Testbench for tlul_lsu_host: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level model.

module tb_tlul_lsu_host;
  import tlul_pkg::*;

  localparam int unsigned MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, gnt, rvalid, err, busy, unexp;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  tl_h2d_t     tl_h;
  tl_d2h_t     tl_d;

  logic        a_ready, d_valid, d_error;
  tl_d_op_e    d_opcode;
  logic [7:0]  d_source;
  logic [31:0] d_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    tl_d          = '0;
    tl_d.d_valid  = d_valid;
    tl_d.d_opcode = d_opcode;
    tl_d.d_size   = 2'd2;
    tl_d.d_source = d_source;
    tl_d.d_data   = d_data;
    tl_d.d_error  = d_error;
    tl_d.a_ready  = a_ready;
  end

  tlul_lsu_host #(.MaxOutstanding(MaxOut), .SrcW(3)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .gnt_o    (gnt),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .busy_o   (busy),
    .unexp_o  (unexp),
    .tl_h_o   (tl_h),
    .tl_h_i   (tl_d)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    d_valid = 1'b0; d_opcode = AccessAck; d_source = '0; d_data = '0; d_error = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    a_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  exp_op;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    int          inject;     // 0 none, 1 d_error, 2 wrong source, 3 wrong opcode
    logic [31:0] rsp_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int src);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be; a_ready = 1'b1;
    #1;
    check({v.name, "_gnt"}, gnt, 1'b1);
    step();
    req = 1'b0;
    check({v.name, "_avalid"}, tl_h.a_valid, 1'b1);
    check({v.name, "_opcode"}, tl_h.a_opcode, v.exp_op);
    check({v.name, "_addr"},   tl_h.a_address, v.exp_addr);
    check({v.name, "_mask"},   tl_h.a_mask, v.exp_mask);
    check({v.name, "_data"},   tl_h.a_data, v.exp_data);
    check({v.name, "_size"},   tl_h.a_size, 2'd2);
    check({v.name, "_param"},  tl_h.a_param, 3'd0);
    check({v.name, "_source"}, tl_h.a_source, src);
    check({v.name, "_dready"}, tl_h.d_ready, 1'b1);
    step();
    check({v.name, "_adrop"}, tl_h.a_valid, 1'b0);
    check({v.name, "_busy"},  busy, 1'b1);
    d_valid  = 1'b1;
    d_opcode = ((v.we == 1'b1) ^ (v.inject == 3)) ? AccessAck : AccessAckData;
    d_source = 8'(src ^ ((v.inject == 2) ? 1 : 0));
    d_error  = (v.inject == 1);
    d_data   = v.rsp_data;
    step();
    idle_inputs();
    check({v.name, "_rvalid"}, rvalid, 1'b1);
    check({v.name, "_rdata"},  rdata, v.exp_rdata);
    check({v.name, "_err"},    err, v.exp_err);
    check({v.name, "_idle"},   busy, 1'b0);
    step();
    check({v.name, "_pulse"},  rvalid, 1'b0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  op;
    int          src;
  } txn_t;

  initial begin
    tl_h2d_t exp_h;
    txn_t    inflight[$];
    txn_t    a_q[$];
    txn_t    dev_q[$];
    txn_t    t;
    int      next_src;
    int      inj;
    logic    exp_rv, exp_err, exp_gnt;
    logic [31:0] exp_rd;

    a_ready = 1'b1;
    idle_inputs();

    vecs[0] = '{name:"rd104",  we:0, addr:32'h0000_0104, wdata:32'h0, be:4'h0, exp_op:3'd4,
                exp_addr:32'h104, exp_mask:4'hF, exp_data:32'h0, inject:0,
                rsp_data:32'hDEAD_BEEF, exp_rdata:32'hDEAD_BEEF, exp_err:0};
    vecs[1] = '{name:"wrpart", we:1, addr:32'h0000_0202, wdata:32'h1234_5678, be:4'b0011, exp_op:3'd1,
                exp_addr:32'h200, exp_mask:4'h3, exp_data:32'h1234_5678, inject:0,
                rsp_data:32'hAAAA_5555, exp_rdata:32'h0, exp_err:0};
    vecs[2] = '{name:"wrfull", we:1, addr:32'h0000_0202, wdata:32'h1234_5678, be:4'hF, exp_op:3'd0,
                exp_addr:32'h200, exp_mask:4'hF, exp_data:32'h1234_5678, inject:0,
                rsp_data:32'h0, exp_rdata:32'h0, exp_err:0};
    vecs[3] = '{name:"wrbe0",  we:1, addr:32'h0000_0407, wdata:32'h0000_0001, be:4'h0, exp_op:3'd1,
                exp_addr:32'h404, exp_mask:4'h0, exp_data:32'h1, inject:0,
                rsp_data:32'h0, exp_rdata:32'h0, exp_err:0};
    vecs[4] = '{name:"derr",   we:0, addr:32'h0000_1000, wdata:32'hFFFF_FFFF, be:4'h0, exp_op:3'd4,
                exp_addr:32'h1000, exp_mask:4'hF, exp_data:32'h0, inject:1,
                rsp_data:32'h1111_2222, exp_rdata:32'h1111_2222, exp_err:1};
    vecs[5] = '{name:"badsrc", we:0, addr:32'hFFFF_FFFF, wdata:32'h0, be:4'h0, exp_op:3'd4,
                exp_addr:32'hFFFF_FFFC, exp_mask:4'hF, exp_data:32'h0, inject:2,
                rsp_data:32'h3333_4444, exp_rdata:32'h3333_4444, exp_err:1};
    vecs[6] = '{name:"badoprd", we:0, addr:32'h0000_0008, wdata:32'h0, be:4'h0, exp_op:3'd4,
                exp_addr:32'h8, exp_mask:4'hF, exp_data:32'h0, inject:3,
                rsp_data:32'h5555_6666, exp_rdata:32'h5555_6666, exp_err:1};
    vecs[7] = '{name:"badopwr", we:1, addr:32'h0000_0010, wdata:32'h7777_8888, be:4'b1100, exp_op:3'd1,
                exp_addr:32'h10, exp_mask:4'hC, exp_data:32'h7777_8888, inject:3,
                rsp_data:32'h9999_0000, exp_rdata:32'h0, exp_err:1};

    // Reset state
    do_reset();
    exp_h = '0;
    exp_h.d_ready = 1'b1;
    check("reset_tl_h",  tl_h, exp_h);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err",   err, 1'b0);
    check("reset_unexp", unexp, 1'b0);
    check("reset_busy",  busy, 1'b0);
    check("reset_gnt",   gnt, 1'b1);

    // Directed single transactions; sources wrap 0,1,0,1...
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], i % MaxOut);
    end

    // Backpressure and full
    do_reset();
    a_ready = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h40;
    #1;
    check("bp_gnt0", gnt, 1'b1);
    step();
    addr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", tl_h.a_valid, 1'b1);
      check("bp_hold_addr",  tl_h.a_address, 32'h40);
      check("bp_hold_src",   tl_h.a_source, 8'd0);
      check("bp_hold_gnt",   gnt, 1'b0);
      step();
    end
    a_ready = 1'b1;
    #1;
    check("bp_release_gnt", gnt, 1'b1);
    step();
    addr = 32'hC0;
    #1;
    check("bp_second_src",  tl_h.a_source, 8'd1);
    check("bp_second_addr", tl_h.a_address, 32'h80);
    check("bp_full_gnt",    gnt, 1'b0);
    step();
    check("bp_drop_valid", tl_h.a_valid, 1'b0);
    check("bp_full_gnt2",  gnt, 1'b0);
    req = 1'b0;
    d_valid = 1'b1; d_opcode = AccessAckData; d_source = 8'd0; d_data = 32'h0A0A_0A0A;
    #1;
    check("bp_gnt_on_dvalid", gnt, 1'b1);
    step();
    d_source = 8'd1; d_data = 32'h0B0B_0B0B;
    check("bp_rv1",   rvalid, 1'b1);
    check("bp_rd1",   rdata, 32'h0A0A_0A0A);
    check("bp_err1",  err, 1'b0);
    step();
    idle_inputs();
    check("bp_rv2",   rvalid, 1'b1);
    check("bp_rd2",   rdata, 32'h0B0B_0B0B);
    check("bp_err2",  err, 1'b0);
    step();
    check("bp_done_rv",   rvalid, 1'b0);
    check("bp_done_busy", busy, 1'b0);

    // Unexpected response
    do_reset();
    d_valid = 1'b1; d_opcode = AccessAckData; d_source = 8'd0; d_data = 32'h1234;
    step();
    idle_inputs();
    check("unexp_rvalid", rvalid, 1'b0);
    check("unexp_set",    unexp, 1'b1);
    check("unexp_busy",   busy, 1'b0);
    step();
    step();
    check("unexp_held",   unexp, 1'b1);
    do_reset();
    check("unexp_cleared", unexp, 1'b0);

    // Reset mid-transaction, then a stale response
    a_ready = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h50;
    step();
    req = 1'b0;
    check("midrst_avalid", tl_h.a_valid, 1'b1);
    check("midrst_busy",   busy, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("midrst_avalid0", tl_h.a_valid, 1'b0);
    check("midrst_busy0",   busy, 1'b0);
    check("midrst_gnt",     gnt, 1'b1);
    a_ready = 1'b1;
    d_valid = 1'b1; d_opcode = AccessAckData; d_source = 8'd0; d_data = 32'h5;
    step();
    idle_inputs();
    check("midrst_stale_rv",    rvalid, 1'b0);
    check("midrst_stale_unexp", unexp, 1'b1);

    // Randomized run against the transaction-level model
    do_reset();
    next_src = 0;
    exp_rv = 1'b0; exp_err = 1'b0; exp_rd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      check("rnd_rvalid", rvalid, exp_rv);
      if (exp_rv) begin
        check("rnd_rdata", rdata, exp_rd);
        check("rnd_err",   err, exp_err);
      end
      check("rnd_avalid", tl_h.a_valid, a_q.size() != 0);
      if (a_q.size() != 0) begin
        check("rnd_aaddr", tl_h.a_address, a_q[0].addr);
        check("rnd_aop",   tl_h.a_opcode, a_q[0].op);
        check("rnd_amask", tl_h.a_mask, a_q[0].mask);
        check("rnd_adata", tl_h.a_data, a_q[0].data);
        check("rnd_asrc",  tl_h.a_source, a_q[0].src);
      end
      check("rnd_busy",  busy, (inflight.size() != 0) || (a_q.size() != 0));
      check("rnd_unexp", unexp, 1'b0);

      req     = ($urandom_range(0, 99) < 60);
      we      = 1'($urandom_range(0, 1));
      addr    = $urandom;
      wdata   = $urandom;
      be      = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      a_ready = ($urandom_range(0, 99) < 70);
      d_data  = $urandom;
      inj     = 0;
      if (dev_q.size() != 0 && $urandom_range(0, 99) < 60) begin
        inj      = $urandom_range(0, 7);
        inj      = (inj <= 4) ? 0 : inj - 4;
        d_valid  = 1'b1;
        d_opcode = ((dev_q[0].we == 1'b1) ^ (inj == 3)) ? AccessAck : AccessAckData;
        d_source = 8'(dev_q[0].src ^ ((inj == 2) ? 1 : 0));
        d_error  = (inj == 1);
      end else begin
        d_valid  = 1'b0;
        d_opcode = AccessAck;
        d_source = 8'($urandom);
        d_error  = 1'($urandom_range(0, 1));
      end
      #1;
      exp_gnt = ((inflight.size() - (d_valid ? 1 : 0)) < MaxOut) &&
                (a_q.size() == 0 || a_ready);
      check("rnd_gnt", gnt, exp_gnt);

      if (d_valid) begin
        t = inflight.pop_front();
        dev_q.delete(0);
        exp_rv  = 1'b1;
        exp_rd  = t.we ? 32'h0 : d_data;
        exp_err = (inj != 0);
      end else begin
        exp_rv = 1'b0;
      end
      if (a_q.size() != 0 && a_ready) begin
        dev_q.push_back(a_q.pop_front());
      end
      if (req && exp_gnt) begin
        t.we   = we;
        t.addr = addr & 32'hFFFF_FFFC;
        t.mask = we ? be : 4'hF;
        t.data = we ? wdata : 32'h0;
        t.op   = !we ? 3'd4 : ((be == 4'hF) ? 3'd0 : 3'd1);
        t.src  = next_src;
        next_src = (next_src + 1) % MaxOut;
        inflight.push_back(t);
        a_q.push_back(t);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
